// File: rtl/cast_credit_return_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cast_credit_return_if : destination input-port handshake and credit outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface cast_credit_return_if;
    logic        fire;
    logic        pop;
    logic [1:0]  flit_type;
    logic [31:0] credit_upd;
    logic [31:0] pending;
    logic [31:0] total_ret;

    modport master (
        output fire, pop, flit_type,
        input  credit_upd, pending, total_ret
    );

    modport slave (
        input  fire, pop, flit_type,
        output credit_upd, pending, total_ret
    );
endinterface
`default_nettype wire

// File: rtl/cast_credit_return.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cast_credit_return : batches consumed BODY flits into credit_upd pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module cast_credit_return #(
    parameter int unsigned isDST         = 1,
    parameter int unsigned CRD_THRESH    = 8,
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned FLUSH_ON_TAIL = 1,
    parameter logic [1:0]  FLIT_BODY     = 2'b01,
    parameter logic [1:0]  FLIT_TAIL     = 2'b10
) (
    input wire                   clk,
    input wire                   rstn,
    cast_credit_return_if.slave  bus
);

    localparam logic [31:0] c_thresh     = 32'(CRD_THRESH);
    localparam logic [31:0] c_timer_last = 32'(TIMEOUT - 1);
    localparam logic [31:0] c_sat        = 32'hFFFF_FFFF;
    localparam logic        c_dst        = (isDST != 0);
    localparam logic        c_flush      = (FLUSH_ON_TAIL != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] credit_upd_q, credit_upd_d;
    logic [31:0] total_ret_q, total_ret_d;

    logic        w_hs;
    logic        w_consume;
    logic        w_tail;
    logic [31:0] w_acc_next;
    logic        w_emit;

    // A non-destination node never sees a consume, so all state stays at reset.
    assign w_hs       = bus.fire & bus.pop;
    assign w_consume  = c_dst & w_hs & (bus.flit_type == FLIT_BODY);
    assign w_tail     = w_hs & (bus.flit_type == FLIT_TAIL);
    assign w_acc_next = (pending_q == c_sat) ? pending_q
                                             : pending_q + {31'd0, w_consume};

    assign w_emit = c_dst & (w_acc_next != 32'd0) &
                    ((w_acc_next >= c_thresh) |
                     ((state_q == ST_ACCUM) & (timer_q == c_timer_last)) |
                     (c_flush & w_tail));

    always_comb begin
        state_d      = state_q;
        pending_d    = w_acc_next;
        timer_d      = (pending_q != 32'd0) ? timer_q + 32'd1 : 32'd0;
        credit_upd_d = 32'd0;
        total_ret_d  = total_ret_q;
        if (w_emit) begin
            state_d      = ST_EMIT;
            pending_d    = 32'd0;
            timer_d      = 32'd0;
            credit_upd_d = w_acc_next;
            total_ret_d  = total_ret_q + w_acc_next;
        end else if (w_acc_next != 32'd0) begin
            state_d = ST_ACCUM;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            pending_q    <= 32'd0;
            timer_q      <= 32'd0;
            credit_upd_q <= 32'd0;
            total_ret_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            timer_q      <= timer_d;
            credit_upd_q <= credit_upd_d;
            total_ret_q  <= total_ret_d;
        end
    end

    assign bus.credit_upd = credit_upd_q;
    assign bus.pending    = pending_q;
    assign bus.total_ret  = total_ret_q;

endmodule
`default_nettype wire

// File: tb/tb_cast_credit_return.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cast_credit_return : four configurations driven with shared directed stimulus
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cast_credit_return;

    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam int     ND   = 4;
    localparam int     TO   = 64;
    localparam longint MAXV = 64'hFFFF_FFFF;
    // instance 0: A, 1: B (tail flush), 2: C (threshold 1), 3: D (not a destination)
    localparam int P_DST [ND] = '{1, 1, 1, 0};
    localparam int P_THR [ND] = '{8, 8, 1, 8};
    localparam int P_FL  [ND] = '{0, 1, 1, 1};

    logic       clk = 1'b0;
    logic       rstn;
    logic       fire_s;
    logic       pop_s;
    logic [1:0] ft_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cast_credit_return_if if_a ();
    cast_credit_return_if if_b ();
    cast_credit_return_if if_c ();
    cast_credit_return_if if_d ();

    assign if_a.fire = fire_s; assign if_a.pop = pop_s; assign if_a.flit_type = ft_s;
    assign if_b.fire = fire_s; assign if_b.pop = pop_s; assign if_b.flit_type = ft_s;
    assign if_c.fire = fire_s; assign if_c.pop = pop_s; assign if_c.flit_type = ft_s;
    assign if_d.fire = fire_s; assign if_d.pop = pop_s; assign if_d.flit_type = ft_s;

    cast_credit_return #(.isDST(1), .CRD_THRESH(8), .TIMEOUT(TO), .FLUSH_ON_TAIL(0),
                         .FLIT_BODY(BODY), .FLIT_TAIL(TAIL))
        u_a (.clk(clk), .rstn(rstn), .bus(if_a.slave));
    cast_credit_return #(.isDST(1), .CRD_THRESH(8), .TIMEOUT(TO), .FLUSH_ON_TAIL(1),
                         .FLIT_BODY(BODY), .FLIT_TAIL(TAIL))
        u_b (.clk(clk), .rstn(rstn), .bus(if_b.slave));
    cast_credit_return #(.isDST(1), .CRD_THRESH(1), .TIMEOUT(TO), .FLUSH_ON_TAIL(1),
                         .FLIT_BODY(BODY), .FLIT_TAIL(TAIL))
        u_c (.clk(clk), .rstn(rstn), .bus(if_c.slave));
    cast_credit_return #(.isDST(0), .CRD_THRESH(8), .TIMEOUT(TO), .FLUSH_ON_TAIL(1),
                         .FLIT_BODY(BODY), .FLIT_TAIL(TAIL))
        u_d (.clk(clk), .rstn(rstn), .bus(if_d.slave));

    logic [31:0] upd [ND];
    logic [31:0] pnd [ND];
    logic [31:0] tot [ND];
    assign upd[0] = if_a.credit_upd; assign pnd[0] = if_a.pending; assign tot[0] = if_a.total_ret;
    assign upd[1] = if_b.credit_upd; assign pnd[1] = if_b.pending; assign tot[1] = if_b.total_ret;
    assign upd[2] = if_c.credit_upd; assign pnd[2] = if_c.pending; assign tot[2] = if_c.total_ret;
    assign upd[3] = if_d.credit_upd; assign pnd[3] = if_d.pending; assign tot[3] = if_d.total_ret;

    // Reference: credit owed, how long it has been owed, what was paid back.
    longint m_pend [ND];
    longint m_age  [ND];
    longint m_tot  [ND];
    longint m_upd  [ND];
    longint m_cons [ND];

    function automatic longint body_of(int d);
        return (P_DST[d] != 0 && fire_s && pop_s && ft_s == BODY) ? 64'd1 : 64'd0;
    endfunction

    function automatic longint acc_of(int d);
        longint a;
        a = m_pend[d] + body_of(d);
        return (a > MAXV) ? MAXV : a;
    endfunction

    function automatic bit go_of(int d);
        longint a;
        bit     tl;
        a  = acc_of(d);
        tl = fire_s && pop_s && ft_s == TAIL;
        return (P_DST[d] != 0) && (a > 0) &&
               (a >= longint'(P_THR[d]) ||
                (m_pend[d] > 0 && m_age[d] == TO - 1) ||
                (P_FL[d] != 0 && tl));
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < ND; d++) begin
                m_pend[d] <= 0; m_age[d] <= 0; m_tot[d] <= 0;
                m_upd[d]  <= 0; m_cons[d] <= 0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                m_cons[d] <= m_cons[d] + body_of(d);
                if (go_of(d)) begin
                    m_upd[d]  <= acc_of(d);
                    m_tot[d]  <= (m_tot[d] + acc_of(d)) & MAXV;
                    m_pend[d] <= 0;
                    m_age[d]  <= 0;
                end else begin
                    m_upd[d]  <= 0;
                    m_age[d]  <= (m_pend[d] > 0) ? m_age[d] + 1 : 0;
                    m_pend[d] <= acc_of(d);
                end
            end
        end
    end

    task automatic chk(input string nm, input int idx, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            chk("model_credit_upd", d, upd[d], m_upd[d]);
            chk("model_pending",    d, pnd[d], m_pend[d]);
            chk("model_total_ret",  d, tot[d], m_tot[d]);
            chk("conservation",     d, (longint'(tot[d]) + longint'(pnd[d])) & MAXV,
                m_cons[d] & MAXV);
        end
    end

    task automatic cyc(input logic f, input logic p, input logic [1:0] t);
        @(negedge clk);
        fire_s = f;
        pop_s  = p;
        ft_s   = t;
    endtask

    int     first_k;
    int     hits_a;
    int     hits_b;
    longint val_a;
    longint val_b;

    initial begin
        rstn   = 1'b1;
        fire_s = 1'b0;
        pop_s  = 1'b0;
        ft_s   = HEAD;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("reset_credit_upd", d, upd[d], 0);
            chk("reset_pending",    d, pnd[d], 0);
            chk("reset_total_ret",  d, tot[d], 0);
        end
        rstn = 1'b1;
        repeat (2) cyc(0, 0, HEAD);

        // Handshakes that must not count as consumes
        cyc(1, 0, BODY); cyc(0, 1, BODY); cyc(1, 1, HEAD); cyc(0, 0, BODY);
        chk("no_consume_pending", 0, pnd[0], 0);

        // Threshold: eight bodies give one pulse of 8
        repeat (8) cyc(1, 1, BODY);
        cyc(0, 0, HEAD);
        chk("thresh_credit_upd", 0, upd[0], 8);
        chk("thresh_pending",    0, pnd[0], 0);
        chk("thresh_total_ret",  0, tot[0], 8);
        chk("thresh1_total_ret", 2, tot[2], 8);
        cyc(0, 0, HEAD);
        chk("thresh_pulse_once", 0, upd[0], 0);

        // Timeout: three bodies, pulse 64 cycles after the first consume edge
        repeat (3) cyc(1, 1, BODY);
        first_k = -1; hits_a = 0; hits_b = 0; val_a = 0; val_b = 0;
        for (int k = 1; k <= 70; k++) begin
            cyc(0, 0, HEAD);
            if (upd[0] != 0) begin
                hits_a++;
                if (first_k < 0) begin
                    first_k = k;
                    val_a   = upd[0];
                end
            end
            if (upd[1] != 0) begin
                hits_b++;
                val_b = upd[1];
            end
        end
        chk("timeout_cycle",  0, first_k, 63);
        chk("timeout_value",  0, val_a, 3);
        chk("timeout_pulses", 0, hits_a, 1);
        chk("timeout_value",  1, val_b, 3);
        chk("timeout_pulses", 1, hits_b, 1);

        // Tail flush: HEAD, 5 BODY, TAIL
        cyc(1, 1, HEAD);
        repeat (5) cyc(1, 1, BODY);
        cyc(1, 1, TAIL);
        cyc(0, 0, HEAD);
        chk("tail_flush_credit_upd", 1, upd[1], 5);
        chk("no_flush_credit_upd",   0, upd[0], 0);
        chk("no_flush_pending",      0, pnd[0], 5);
        chk("thresh1_total_ret",     2, tot[2], 16);
        cyc(1, 1, TAIL);
        cyc(0, 0, HEAD);
        chk("tail_empty_no_pulse", 1, upd[1], 0);
        repeat (70) cyc(0, 0, HEAD);
        chk("drained_pending",   0, pnd[0], 0);
        chk("drained_total_ret", 0, tot[0], 16);

        // CRD_THRESH==1: back-to-back pulses of 1
        for (int i = 0; i <= 4; i++) begin
            cyc(i < 4, i < 4, BODY);
            if (i >= 1) chk("b2b_credit_upd", 2, upd[2], 1);
        end
        cyc(0, 0, HEAD);
        chk("b2b_end_credit_upd", 2, upd[2], 0);
        chk("b2b_total_ret",      2, tot[2], 20);

        // Asynchronous reset with six credits pending
        repeat (2) cyc(1, 1, BODY);
        cyc(0, 0, HEAD);
        chk("pre_reset_pending", 0, pnd[0], 6);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_pending",    0, pnd[0], 0);
        chk("async_rst_credit_upd", 0, upd[0], 0);
        chk("async_rst_total_ret",  0, tot[0], 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Random traffic; non-destination node must never pulse
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            chk("nodst_credit_upd", 3, upd[3], 0);
        end
        repeat (3) cyc(0, 0, HEAD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cast_credit_return.md
Name: cast_credit_return

Overview:
- Sits at each FC destination node, directly upstream of cast_credit_counter.
- Watches the destination input port and counts body flits the local PE consumes.
- Returns them to the FC start node as one-cycle credit_upd pulses, batched by threshold, idle timeout or packet-tail flush.
- The credit_upd output feeds the credit_upd[x][y] entry of the source counter for this node.

Parameters:
- isDST, 0, 1 = this node is an FC destination; 0 = credit_upd tied to 0, all state held at reset values.
- CRD_THRESH, 8, emit as soon as the accumulated credit reaches this value (1..2^16).
- TIMEOUT, 64, emit pending credit after this many cycles without emission (>=2).
- FLUSH_ON_TAIL, 1, emit all pending credit when a TAIL flit is consumed.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- fire  input  1  destination input port handshake completes this cycle.
- pop  input  1  flit leaves the buffer toward the local PE (credit freed only when pop & fire).
- flit_type  input  2  `HEAD/`BODY/`TAIL encoding from params.svh.
- credit_upd  output  32  credit returned this cycle; 0 when idle.
- pending  output  32  accumulated, not-yet-returned credit.
- total_ret  output  32  running total of returned credit, for logging.

Behaviour:
- Reset: credit_upd=0, pending=0, total_ret=0, timer=0, state=IDLE.
- Reset is asynchronous; asserting it mid-batch discards pending credit with no pulse.
- Credit event (consume) = fire & pop & (flit_type==`BODY). HEAD and TAIL never add credit, matching the FCpl-2 cost per packet charged at the source.
- acc_next = pending + consume, saturating at 2^32-1.
- States:
  - IDLE (pending==0)
  - ACCUM (pending>0)
  - EMIT (one cycle, credit_upd valid)
- Emission condition at a rising edge (evaluated on acc_next), any of:
  - acc_next >= CRD_THRESH;
  - state==ACCUM and timer==TIMEOUT-1 and acc_next>0;
  - FLUSH_ON_TAIL and fire & pop & flit_type==`TAIL and acc_next>0.
- On emission: credit_upd<=acc_next, pending<=0, timer<=0, total_ret<=total_ret+acc_next (wraps mod 2^32). State goes to EMIT for exactly one cycle.
- Pulse timing: credit_upd is nonzero for exactly one cycle. In the next cycle credit_upd<=0 unless another emission fires.
- Back-to-back pulses are legal: a consume during EMIT starts a new batch. With CRD_THRESH==1, every body flit produces its own pulse.
- Latency: consume sampled at edge t gives credit_upd valid in the cycle after edge t when a condition is met. Registered output, no combinational input-to-output path.
- Without emission: pending<=acc_next. timer increments while pending>0 and holds at 0 while pending==0.
- Transitions:
  - IDLE -> ACCUM on consume without emission.
  - ACCUM -> IDLE is only reachable through EMIT.
  - EMIT -> ACCUM if a consume occurred without emission, else -> IDLE.
- Simultaneous consume and emission: the same-cycle flit is included in the emitted value. No credit is lost or double-counted.
- A TAIL with pending==0 produces no pulse; zero pulses are never emitted.
- fire without pop, or pop without fire, is not a consume.
- Invariant: total_ret + pending equals the total number of consumes since reset (mod 2^32).

Test Plan:
- isDST=1, CRD_THRESH=8, FLUSH_ON_TAIL=0; 8 consecutive BODY consumes -> single credit_upd=8 pulse one cycle after the 8th edge; pending=0; total_ret=8.
- 3 BODY consumes then idle, TIMEOUT=64 -> credit_upd=3 exactly 64 cycles after the first consume edge; no further pulses.
- FLUSH_ON_TAIL=1; HEAD, 5 BODY, TAIL -> credit_upd=5 one cycle after the TAIL edge. HEAD and TAIL are never counted.
- CRD_THRESH=1; 4 back-to-back BODY consumes -> four consecutive pulses of 1; total_ret=4.
- Assert rstn low with pending=6 -> outputs return to 0 immediately, with no pulse.
- isDST=0 with random traffic -> credit_upd=0 on every cycle.
